// File: rtl/snoopy_sprite_drawer.sv
// Sprite drawer: erases the previously drawn sprite with the background
// colour, then redraws it from the sprite ROM at the newly sampled position.
// Pixels falling outside the 160x120 screen are suppressed.
module snoopy_sprite_drawer #(
  parameter int          SPRITE_W    = 8,
  parameter int          SPRITE_H    = 8,
  parameter logic [2:0]  BG_COLOUR   = 3'b000,
  parameter logic [2:0]  TRANSPARENT = 3'b101
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] snoopy_x,
  input  logic [6:0] snoopy_y,
  input  logic       frame_tick,
  output logic [5:0] rom_addr,
  input  logic [2:0] rom_data,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DRAIN
  } state_t;

  state_t          r_state;
  logic            r_drawn_valid;
  logic [7:0]      r_old_x;
  logic [6:0]      r_old_y;
  logic [7:0]      r_new_x;
  logic [6:0]      r_new_y;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_pcol;
  logic [RW-1:0]   r_prow;
  logic            r_pvalid;

  logic            w_last;
  logic [8:0]      w_ex;
  logic [7:0]      w_ey;
  logic [8:0]      w_dx;
  logic [7:0]      w_dy;
  logic            w_e_vis;
  logic            w_d_vis;

  // Sums are one bit wider than the operands so off-screen pixels never wrap
  assign w_last  = (r_row == RW'(SPRITE_H - 1)) && (r_col == CW'(SPRITE_W - 1));
  assign w_ex    = {1'b0, r_old_x} + 9'(r_col);
  assign w_ey    = {1'b0, r_old_y} + 8'(r_row);
  assign w_dx    = {1'b0, r_new_x} + 9'(r_pcol);
  assign w_dy    = {1'b0, r_new_y} + 8'(r_prow);
  assign w_e_vis = (w_ex < 9'd160) && (w_ey < 8'd120);
  assign w_d_vis = (w_dx < 9'd160) && (w_dy < 8'd120);

  // Sequencer: position sampling, pixel scan counters and ROM-latency pipeline
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_drawn_valid <= 1'b0;
      r_old_x       <= '0;
      r_old_y       <= '0;
      r_new_x       <= '0;
      r_new_y       <= '0;
      r_col         <= '0;
      r_row         <= '0;
      r_pcol        <= '0;
      r_prow        <= '0;
      r_pvalid      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pvalid <= 1'b0;
          r_col    <= '0;
          r_row    <= '0;
          if (frame_tick) begin
            r_new_x <= snoopy_x;
            r_new_y <= snoopy_y;
            if (!r_drawn_valid)
              r_state <= S_DRAW;
            else if ((snoopy_x != r_old_x) || (snoopy_y != r_old_y))
              r_state <= S_ERASE;
          end
        end
        S_ERASE: begin
          if (w_last) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= S_DRAW;
          end else if (r_col == CW'(SPRITE_W - 1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_DRAW: begin
          // ROM answers one cycle later, so the plotted coordinate trails the address
          r_pvalid <= 1'b1;
          r_pcol   <= r_col;
          r_prow   <= r_row;
          if (w_last) begin
            r_col   <= '0;
            r_row   <= '0;
            r_state <= S_DRAIN;
          end else if (r_col == CW'(SPRITE_W - 1)) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_DRAIN: begin
          r_pvalid      <= 1'b0;
          r_old_x       <= r_new_x;
          r_old_y       <= r_new_y;
          r_drawn_valid <= 1'b1;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Pixel outputs decoded from the scan registers; draw colour comes straight from the ROM
  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    rom_addr   = '0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_ERASE: begin
        vga_x      = w_ex[7:0];
        vga_y      = w_ey[6:0];
        vga_colour = BG_COLOUR;
        vga_plot   = w_e_vis;
      end
      S_DRAW, S_DRAIN: begin
        if (r_state == S_DRAW)
          rom_addr = 6'(r_row) * 6'(SPRITE_W) + 6'(r_col);
        if (r_pvalid) begin
          vga_x      = w_dx[7:0];
          vga_y      = w_dy[6:0];
          vga_colour = rom_data;
          vga_plot   = (rom_data != TRANSPARENT) && w_d_vis;
        end
      end
      default: ;
    endcase
  end

endmodule
